// File: rtl/seq_divider_if.sv
// Operand/result handshake bundle for seq_divider.
// master drives operands and consumes results; slave is the divider.
interface seq_divider_if #(
  parameter int N = 4
);
  logic           in_valid;
  logic           in_ready;
  logic [2*N-1:0] dividend;
  logic [N-1:0]   divisor;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] quotient;
  logic [N-1:0]   remainder;
  logic           div_by_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// Unsigned restoring divider, 2N/N bits, one quotient bit per clock.
// Operands latch on accept; results hold in DONE until out_ready.
module seq_divider #(
  parameter int N = 4
) (
  input logic          clk,
  input logic          rst_n,
  seq_divider_if.slave bus
);
  localparam int W  = 2 * N;
  localparam int CW = $clog2(W) + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t         state, state_n;
  logic [CW-1:0]  cnt;
  logic [N-1:0]   p, p_n;
  logic [N:0]     t;
  logic [W-1:0]   q, q_n, quo;
  logic [N-1:0]   dvs, rem;
  logic           dbz;
  logic           accept, last;

  assign accept = (state == IDLE) && bus.in_valid;
  assign last   = (cnt == CW'(W - 1));
  assign t      = {p, q[W-1]};

  // T fits in N+1 bits, so the compare/subtract never overflows
  always_comb begin
    p_n = t[N-1:0];
    q_n = {q[W-2:0], 1'b0};
    if (t >= {1'b0, dvs}) begin
      p_n    = N'(t - {1'b0, dvs});
      q_n[0] = 1'b1;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:
        if (bus.in_valid)
          state_n = (bus.divisor == '0) ? DONE : BUSY;
      BUSY:
        if (last) state_n = DONE;
      DONE:
        if (bus.out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      p   <= '0;
      q   <= '0;
      dvs <= '0;
      quo <= '0;
      rem <= '0;
      dbz <= 1'b0;
    end else if (accept) begin
      dvs <= bus.divisor;
      if (bus.divisor == '0) begin
        quo <= '1;
        rem <= bus.dividend[N-1:0];
        dbz <= 1'b1;
      end else begin
        cnt <= '0;
        p   <= '0;
        q   <= bus.dividend;
      end
    end else if (state == BUSY) begin
      cnt <= cnt + CW'(1);
      p   <= p_n;
      q   <= q_n;
      if (last) begin
        quo <= q_n;
        rem <= p_n;
        dbz <= 1'b0;
      end
    end
  end

  assign bus.in_ready    = (state == IDLE);
  assign bus.out_valid   = (state == DONE);
  assign bus.quotient    = quo;
  assign bus.remainder   = rem;
  assign bus.div_by_zero = dbz;
endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: directed table, reset abort, full operand sweep
// against an arithmetic model with busy-time operand jitter.
module tb_seq_divider;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  seq_divider_if #(.N(4)) bus ();

  seq_divider #(.N(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [3:0] b;
    int         hold;
    logic [7:0] eq;
    logic [3:0] er;
    logic       ez;
    int         elat;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Starts at a negedge in IDLE; returns the captured result and the
  // number of edges after the accept edge until out_valid was seen.
  task automatic run_op(input logic [7:0] a, input logic [3:0] b,
                        input int hold, input bit jitter,
                        output logic [7:0] q, output logic [3:0] r,
                        output logic z, output int lat);
    int e;
    bus.dividend  = a;
    bus.divisor   = b;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    e = 0;
    while (!bus.out_valid && e < 40) begin
      if (jitter) begin
        bus.in_valid = 1'($urandom);
        bus.dividend = 8'($urandom);
        bus.divisor  = 4'($urandom);
      end
      @(negedge clk);
      e++;
    end
    bus.in_valid = 1'b0;
    lat = e;
    q = bus.quotient;
    r = bus.remainder;
    z = bus.div_by_zero;
    if (e >= 40) begin
      check("timeout", 32'(e), 32'd8);
      return;
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", 32'(bus.out_valid), 32'd1);
      check("hold_inrdy", 32'(bus.in_ready), 32'd0);
      check("hold_quo", 32'(bus.quotient), 32'(q));
      check("hold_rem", 32'(bus.remainder), 32'(r));
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("rel_valid", 32'(bus.out_valid), 32'd0);
    check("rel_inrdy", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    logic [7:0] q;
    logic [3:0] r;
    logic       z;
    int         lat;
    int         seen;
    logic [7:0] mq;
    logic [3:0] mr;

    tbl[0] = '{8'd84,  4'd6,  0, 8'd14,  4'd0, 1'b0, 8};
    tbl[1] = '{8'd0,   4'd5,  0, 8'd0,   4'd0, 1'b0, 8};
    tbl[2] = '{8'd200, 4'd7,  0, 8'd28,  4'd4, 1'b0, 8};
    tbl[3] = '{8'd255, 4'd1,  0, 8'd255, 4'd0, 1'b0, 8};
    tbl[4] = '{8'd100, 4'd0,  0, 8'hFF,  4'd4, 1'b1, 0};
    tbl[5] = '{8'd255, 4'd15, 5, 8'd17,  4'd0, 1'b0, 8};

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    repeat (2) @(negedge clk);
    check("rst_inrdy", 32'(bus.in_ready), 32'd1);
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_quo", 32'(bus.quotient), 32'd0);
    check("rst_rem", 32'(bus.remainder), 32'd0);
    check("rst_dbz", 32'(bus.div_by_zero), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].hold, 1'b0, q, r, z, lat);
      check($sformatf("tbl%0d_lat", i), 32'(lat), 32'(tbl[i].elat));
      check($sformatf("tbl%0d_quo", i), 32'(q), 32'(tbl[i].eq));
      check($sformatf("tbl%0d_rem", i), 32'(r), 32'(tbl[i].er));
      check($sformatf("tbl%0d_dbz", i), 32'(z), 32'(tbl[i].ez));
    end

    // abort 200/7 three cycles into BUSY
    bus.dividend = 8'd200;
    bus.divisor  = 4'd7;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_inrdy", 32'(bus.in_ready), 32'd1);
    check("abort_valid", 32'(bus.out_valid), 32'd0);
    check("abort_quo", 32'(bus.quotient), 32'd0);
    check("abort_rem", 32'(bus.remainder), 32'd0);
    check("abort_dbz", 32'(bus.div_by_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    check("abort_noresult", 32'(seen), 32'd0);
    run_op(8'd84, 4'd6, 0, 1'b0, q, r, z, lat);
    check("post_lat", 32'(lat), 32'd8);
    check("post_quo", 32'(q), 32'd14);
    check("post_rem", 32'(r), 32'd0);

    // full operand sweep with random jitter and backpressure
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 16; b++) begin
        run_op(8'(a), 4'(b), int'($urandom_range(0, 2)),
               1'($urandom), q, r, z, lat);
        if (b == 0) begin
          mq = 8'hFF;
          mr = 4'(a % 16);
        end else begin
          mq = 8'(a / b);
          mr = 4'(a % b);
        end
        check($sformatf("sw%0d/%0d_quo", a, b), 32'(q), 32'(mq));
        check($sformatf("sw%0d/%0d_rem", a, b), 32'(r), 32'(mr));
        check($sformatf("sw%0d/%0d_dbz", a, b), 32'(z), 32'(b == 0));
        check($sformatf("sw%0d/%0d_lat", a, b), 32'(lat),
              (b == 0) ? 32'd0 : 32'd8);
        if (b != 0) begin
          check($sformatf("sw%0d/%0d_mul", a, b),
                32'(int'(q) * b + int'(r)), 32'(a));
          check($sformatf("sw%0d/%0d_rlt", a, b),
                32'(int'(r) < b), 32'd1);
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multi-cycle unsigned restoring divider; the inverse operation of the team's combinational 4x4 multiplier.
- Takes a 2N-bit dividend and an N-bit divisor, and returns a 2N-bit quotient and an N-bit remainder.
- Computes one quotient bit per clock and uses valid/ready handshakes on both input and output.
- Feeds multiply/divide round-trip checking in the lab datapath: the product of the multiplier divided by one operand returns the other with remainder 0.

Parameters:
- N, 4, divisor and remainder width; the dividend and quotient are 2N bits wide.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands present on dividend/divisor
- in_ready  output  1  block can accept operands
- dividend  input  2N  unsigned dividend
- divisor  input  N  unsigned divisor
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts the result
- quotient  output  2N  unsigned quotient
- remainder  output  N  unsigned remainder
- div_by_zero  output  1  set with out_valid when divisor was 0

Behaviour:
- One clock, clk. rst_n is asynchronous and active-low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, div_by_zero=0, internal counter and partial remainder = 0.
- Reset asserted mid-operation aborts the operation immediately. No result is produced for the aborted operation.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - BUSY: in_ready=0, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- Accept: on a clk edge in IDLE with in_valid=1, latch dividend and divisor.
  - If divisor!=0: go to BUSY, set counter=0, partial remainder P (N+1 bits)=0, quotient shift register Q=dividend.
  - If divisor==0: go straight to DONE with quotient={2N{1'b1}}, remainder=dividend[N-1:0], div_by_zero=1.
- BUSY step, one per edge:
  - T={P[N-1:0],Q[2N-1]}, an (N+1)-bit value.
  - If T>=divisor: P=T-divisor and shift 1 into Q LSB. Otherwise P=T and shift 0 into Q LSB.
  - counter increments on each step.
  - After exactly 2N BUSY edges, go to DONE with quotient=Q, remainder=P[N-1:0], div_by_zero=0.
- Latency: call the accept edge edge 0. out_valid is first high after edge 2N; for N=4, that is 8 cycles after acceptance. Divide-by-zero: out_valid is high after edge 0 (1 cycle).
- DONE: quotient, remainder and div_by_zero hold stable for as long as out_valid=1 and out_ready=0. Backpressure is unbounded.
- Release: on an edge with out_valid=1 and out_ready=1, go to IDLE and set out_valid=0. The output registers keep their last values.
- in_ready=0 during the release cycle. A new operation can be accepted at the earliest on the edge after returning to IDLE.
- in_valid is ignored outside IDLE. Input changes during BUSY do not affect the result because operands are latched at acceptance.
- Invariants, checkable every DONE with divisor!=0:
  - quotient*divisor+remainder == dividend
  - remainder < divisor
- Edge cases:
  - Dividend 0 gives quotient 0, remainder 0.
  - Divisor 1 gives quotient=dividend, remainder 0.
  - Quotient may use the full 2N bits, e.g. 255/1=255.
- All arithmetic is unsigned. The subtraction uses N+1 bits so that T>=divisor never overflows.

Test Plan:
- Reset, then dividend=8'd84, divisor=4'd6, out_ready=1 -> out_valid exactly 8 cycles after accept, quotient=14, remainder=0, div_by_zero=0; back in IDLE with in_ready=1 one cycle later.
- dividend=200, divisor=7 -> quotient=28, remainder=4. Then dividend=255, divisor=1 -> quotient=255, remainder=0.
- dividend=100, divisor=0 -> out_valid 1 cycle after accept, quotient=8'hFF, remainder=4, div_by_zero=1.
- dividend=255, divisor=15 with out_ready held 0 for 5 cycles after out_valid -> quotient=17 and remainder=0 stay stable, out_valid stays 1, in_ready stays 0; release on the first out_ready=1 edge.
- Accept 200/7, drop rst_n after 3 BUSY cycles -> outputs go to reset values immediately. After release, 84/6 runs cleanly and returns 14 remainder 0.
- Random sweep of all 256x16 operand pairs, each followed by a multiplier cross-check (quotient*divisor+remainder==dividend, remainder<divisor); also toggle in_valid and operands during BUSY -> no effect on the result.
